// File: rtl/wb_sram_arbiter_pkg.sv
// Shared definitions for the SRAM-side Wishbone fabric: bus width defaults
// (also used by uart2wb and wb2spi), arbiter state encoding and a helper
// for sizing the watchdog counter.
package wb_sram_arbiter_pkg;

  localparam int ADR_W_DEF = 23;  // SRAM byte address width
  localparam int DAT_W_DEF = 8;   // SRAM data width

  // Arbiter states, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT0  = 2'd1;
  localparam logic [1:0] ST_GNT1  = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  // Width able to hold 0..limit; at least one bit so a disabled watchdog
  // still elaborates.
  function automatic int cnt_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_sram_arbiter_if.sv
// One Wishbone classic link. The master modport drives the request side,
// the slave modport drives the response side.
interface wb_sram_arbiter_if
  import wb_sram_arbiter_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
) ();

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;   // master -> slave write data
  logic [DAT_W-1:0] dat_r;   // slave -> master read data
  logic             ack;
  logic             err;
  logic             rty;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_watchdog.sv
// Slave-cycle watchdog: counts stalled strobe cycles while a grant is
// active and flags the cycle on which the TIMEOUT-th stall occurs.
// A termination (ack/err/rty) in that same cycle suppresses the flag.
module wb_watchdog
  import wb_sram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023  // 0 disables the watchdog
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,   // a master currently owns the slave
  input  logic stb_i,      // slave strobe as driven to the slave
  input  logic term_i,     // ack | err | rty from the slave
  output logic expire_o
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] count_q, count_d;
  logic             stall;

  assign stall = active_i & stb_i & ~term_i;

  // The count before this cycle equals TIMEOUT-1, so this is the TIMEOUT-th stall.
  assign expire_o = (TIMEOUT != 0) && stall && (count_q == CNT_LAST);

  // Next count: clear on termination or when no grant, saturating increment on stall.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (!active_i || term_i) begin
      count_d = '0;
    end else if (stall && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone classic arbiter in front of the wb2spi SRAM port.
// Master 0 is the uart2wb host link, master 1 the edit-distance engine.
// Whole bus cycles are granted round-robin; a watchdog aborts slave
// cycles that never terminate.
module wb_sram_arbiter
  import wb_sram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023  // stalled stb cycles before abort; 0 disables
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_sram_arbiter_if.slave   m0_if,
  wb_sram_arbiter_if.slave   m1_if,
  wb_sram_arbiter_if.master  s_if,
  output logic [1:0]         grant_o,
  output logic               timeout_o
);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;   // most recently granted master; owner while not idle
  logic       in_gnt;
  logic       own_cyc;
  logic       term;
  logic       expire;

  assign in_gnt  = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign own_cyc = last_q ? m1_if.cyc : m0_if.cyc;
  assign term    = s_if.ack | s_if.err | s_if.rty;
  assign grant_o = (state_q == ST_IDLE) ? 2'b00 : (last_q ? 2'b10 : 2'b01);

  // Forward the owning master's request to the slave only while granted.
  always_comb begin
    s_if.cyc   = 1'b0;
    s_if.stb   = 1'b0;
    s_if.we    = 1'b0;
    s_if.adr   = '0;
    s_if.dat_w = '0;
    if (in_gnt) begin
      if (last_q) begin
        s_if.cyc   = m1_if.cyc;
        s_if.stb   = m1_if.stb;
        s_if.we    = m1_if.we;
        s_if.adr   = m1_if.adr;
        s_if.dat_w = m1_if.dat_w;
      end else begin
        s_if.cyc   = m0_if.cyc;
        s_if.stb   = m0_if.stb;
        s_if.we    = m0_if.we;
        s_if.adr   = m0_if.adr;
        s_if.dat_w = m0_if.dat_w;
      end
    end
  end

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (in_gnt),
    .stb_i    (s_if.stb),
    .term_i   (term),
    .expire_o (expire)
  );

  // Read data is broadcast; terminations reach only the granted master.
  assign m0_if.dat_r = s_if.dat_r;
  assign m1_if.dat_r = s_if.dat_r;
  assign m0_if.ack   = in_gnt & ~last_q & s_if.ack;
  assign m0_if.err   = in_gnt & ~last_q & (s_if.err | expire);
  assign m0_if.rty   = in_gnt & ~last_q & s_if.rty;
  assign m1_if.ack   = in_gnt &  last_q & s_if.ack;
  assign m1_if.err   = in_gnt &  last_q & (s_if.err | expire);
  assign m1_if.rty   = in_gnt &  last_q & s_if.rty;
  assign timeout_o   = expire;

  // Grant FSM: registered grant, hold for the whole cyc, always pass through IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_if.cyc && m1_if.cyc) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
          last_d  = ~last_q;
        end else if (m0_if.cyc) begin
          state_d = ST_GNT0;
          last_d  = 1'b0;
        end else if (m1_if.cyc) begin
          state_d = ST_GNT1;
          last_d  = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (expire) begin
          state_d = ST_ABORT;
        end else if (!own_cyc) begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset favours master 0 at the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Self-checking bench for wb_sram_arbiter with TIMEOUT=8. A vector table
// drives one clock per record; hand-written sequences cover multi-beat
// ownership, watchdog expiry and an ack landing on the expiry cycle.
module tb_wb_sram_arbiter;
  import wb_sram_arbiter_pkg::*;

  localparam logic [ADR_W_DEF-1:0] M0_ADR = 23'h000010;
  localparam logic [DAT_W_DEF-1:0] M0_DAT = 8'hA5;
  localparam logic [ADR_W_DEF-1:0] M1_ADR = 23'h000123;
  localparam logic [DAT_W_DEF-1:0] M1_DAT = 8'h3C;

  typedef struct packed {
    logic rst;
    logic m0c, m0s;
    logic m1c, m1s;
    logic ack, err, rty;
  } in_t;

  typedef struct packed {
    logic [1:0] grant;
    logic scyc, sstb;
    logic m0ack, m0err, m0rty;
    logic m1ack, m1err, m1rty;
    logic tmo;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       timeout;
  int         checks = 0;
  int         errors = 0;

  wb_sram_arbiter_if m0_bus ();
  wb_sram_arbiter_if m1_bus ();
  wb_sram_arbiter_if s_bus ();

  wb_sram_arbiter #(.TIMEOUT(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0_if     (m0_bus),
    .m1_if     (m1_bus),
    .s_if      (s_bus),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply_in(input in_t v);
    rst        = v.rst;
    m0_bus.cyc = v.m0c;
    m0_bus.stb = v.m0s;
    m1_bus.cyc = v.m1c;
    m1_bus.stb = v.m1s;
    s_bus.ack  = v.ack;
    s_bus.err  = v.err;
    s_bus.rty  = v.rty;
  endtask

  // Drive at the falling edge, then let combinational outputs settle.
  task automatic step(input in_t v);
    @(negedge clk);
    apply_in(v);
    #1;
  endtask

  function automatic out_t sample();
    out_t o;
    o = {grant, s_bus.cyc, s_bus.stb,
         m0_bus.ack, m0_bus.err, m0_bus.rty,
         m1_bus.ack, m1_bus.err, m1_bus.rty, timeout};
    return o;
  endfunction

  // Slave-side request fields expected for a given grant.
  function automatic logic [31:0] exp_bus(input logic [1:0] g);
    case (g)
      2'b01:   return {1'b1, M0_ADR, M0_DAT};
      2'b10:   return {1'b0, M1_ADR, M1_DAT};
      default: return 32'h0;
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int   m1_acks;
    out_t o;

    m0_bus.we = 1'b1; m0_bus.adr = M0_ADR; m0_bus.dat_w = M0_DAT;
    m1_bus.we = 1'b0; m1_bus.adr = M1_ADR; m1_bus.dat_w = M1_DAT;
    s_bus.dat_r = 8'h5A;
    apply_in(in_t'(8'b1_00_00_000));

    //               r_m0_m1_aer         grant_cs_m0aer_m1aer_t
    vecs.push_back({8'b0_11_00_000, 11'b00_00_000_000_0}); // m0 alone, idle
    vecs.push_back({8'b0_11_00_000, 11'b01_11_000_000_0}); // s_cyc 1 clk later
    vecs.push_back({8'b0_11_00_100, 11'b01_11_100_000_0}); // ack to m0
    vecs.push_back({8'b0_00_00_000, 11'b01_00_000_000_0}); // m0 drops cyc
    vecs.push_back({8'b0_00_11_000, 11'b00_00_000_000_0}); // m1 alone, idle
    vecs.push_back({8'b0_00_11_010, 11'b10_11_000_010_0}); // err to m1
    vecs.push_back({8'b0_11_11_100, 11'b10_11_000_100_0}); // ack to m1 only
    vecs.push_back({8'b0_11_11_001, 11'b10_11_000_001_0}); // rty to m1 only
    vecs.push_back({8'b0_11_00_000, 11'b10_00_000_000_0}); // m1 drops cyc
    vecs.push_back({8'b0_11_00_000, 11'b00_00_000_000_0}); // dead cycle
    vecs.push_back({8'b0_11_00_100, 11'b01_11_100_000_0}); // m0 granted
    vecs.push_back({8'b0_00_00_000, 11'b01_00_000_000_0});
    vecs.push_back({8'b1_00_00_000, 11'b00_00_000_000_0}); // reset while idle
    vecs.push_back({8'b0_11_11_000, 11'b00_00_000_000_0}); // contention after reset
    vecs.push_back({8'b0_11_11_100, 11'b01_11_100_000_0}); // m0 wins
    vecs.push_back({8'b0_00_11_000, 11'b01_00_000_000_0}); // m0 drops
    vecs.push_back({8'b0_00_11_000, 11'b00_00_000_000_0}); // dead cycle
    vecs.push_back({8'b0_11_11_000, 11'b10_11_000_000_0}); // m1 granted 2 clks later
    vecs.push_back({8'b1_11_11_000, 11'b10_11_000_000_0}); // reset during GNT1
    vecs.push_back({8'b0_11_11_000, 11'b00_00_000_000_0}); // bus dropped
    vecs.push_back({8'b0_11_11_000, 11'b01_11_000_000_0}); // m0 favoured again
    vecs.push_back({8'b0_00_00_000, 11'b01_00_000_000_0});
    vecs.push_back({8'b0_00_00_000, 11'b00_00_000_000_0});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", sample(), 11'b0);
    check("reset_slave_req", {s_bus.we, s_bus.adr, s_bus.dat_w}, 32'h0);
    check("reset_m0_dat", m0_bus.dat_r, 8'h5A);
    check("reset_m1_dat", m1_bus.dat_r, 8'h5A);

    // Table
    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].i);
      check($sformatf("vec%0d_out", k), sample(), vecs[k].o);
      check($sformatf("vec%0d_bus", k), {s_bus.we, s_bus.adr, s_bus.dat_w},
            exp_bus(vecs[k].o.grant));
    end

    // m1 owns the bus for 3 beats while m0 waits (last contention went to m0)
    s_bus.dat_r = 8'hC3;
    step(in_t'(8'b0_11_11_000));
    check("beats_idle_grant", grant, 2'b00);
    m1_acks = 0;
    for (int b = 0; b < 3; b++) begin
      step(in_t'(8'b0_11_11_100));
      check($sformatf("beat%0d_grant", b), grant, 2'b10);
      check($sformatf("beat%0d_m0_ack", b), m0_bus.ack, 1'b0);
      if (m1_bus.ack === 1'b1) m1_acks++;
      step(in_t'(8'b0_11_10_000));
      check($sformatf("gap%0d_grant", b), grant, 2'b10);
      check($sformatf("gap%0d_sstb", b), s_bus.stb, 1'b0);
    end
    check("beats_m1_acks", m1_acks, 3);
    check("beats_m1_dat", m1_bus.dat_r, 8'hC3);
    step(in_t'(8'b0_11_00_000));
    check("beats_drop_grant", grant, 2'b10);
    step(in_t'(8'b0_11_00_000));
    check("beats_dead_grant", grant, 2'b00);
    step(in_t'(8'b0_11_00_000));
    check("beats_m0_grant", grant, 2'b01);
    step(in_t'(8'b0_00_00_000));
    step(in_t'(8'b0_00_00_000));

    // Watchdog expiry: slave never terminates
    step(in_t'(8'b0_11_00_000));
    for (int c = 1; c <= 8; c++) begin
      step(in_t'(8'b0_11_00_000));
      o = sample();
      check($sformatf("wd_stall%0d", c), o,
            {2'b01, 2'b11, 1'b0, (c == 8), 1'b0, 3'b000, (c == 8)});
    end
    step(in_t'(8'b0_11_00_000));
    check("abort_outputs", sample(), {2'b01, 2'b00, 6'b0, 1'b0});
    step(in_t'(8'b0_00_00_000));
    check("abort_hold_scyc", s_bus.cyc, 1'b0);
    step(in_t'(8'b0_00_00_000));
    check("abort_exit_grant", grant, 2'b00);

    // Ack on the exact expiry cycle wins
    step(in_t'(8'b0_11_00_000));
    for (int c = 1; c <= 7; c++) begin
      step(in_t'(8'b0_11_00_000));
      check($sformatf("race_stall%0d_err", c), {m0_bus.err, timeout}, 2'b00);
    end
    step(in_t'(8'b0_11_00_100));
    check("race_ack_cycle", sample(), {2'b01, 2'b11, 3'b100, 3'b000, 1'b0});
    step(in_t'(8'b0_11_00_000));
    check("race_no_abort", sample(), {2'b01, 2'b11, 3'b000, 3'b000, 1'b0});
    step(in_t'(8'b0_00_00_000));
    step(in_t'(8'b0_00_00_000));
    check("race_end_grant", grant, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
